// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Arbitrates the single physical-memory port between L2 line fills and the
// eviction write buffer (EWB). Only one pmem command is outstanding at a time.
// Arbitration happens only in IDLE. The winning address and data are latched
// on the transition edge. The command is driven from the following cycle until
// pmem_resp.
//
// Read/write priority: same-line hazard first, then a starved write, then a
// read, then a write. A write counts as starved once STARVE_LIMIT consecutive
// reads have been granted while it was pending.
//
// Optional feature macro: EWB_ARB_FWD_EN
//   defined   : a fill that hits the line held in the EWB is answered
//               directly from ewb_wdata in a one-cycle FWD state, with no pmem
//               access. The EWB write stays pending.
//   undefined : the hazard forces the write to drain first, and the read is
//               granted from the next IDLE.
//
// Parameters
//   STARVE_LIMIT     max consecutive read grants while a write waits (1..7)
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   l2_pmem_read     L2 fill request, held until l2_resp
//   l2_pmem_raddress fill address (16b)
//   l2_rdata         fill line (128b), zero unless l2_resp
//   l2_resp          one-cycle fill-complete pulse
//   ewb_write        EWB holds a dirty line, held until ewb_done
//   ewb_address      buffered line address (16b)
//   ewb_wdata        buffered line data (128b)
//   ewb_done         one-cycle write-drained pulse
//   pmem_read        physical memory read command
//   pmem_write       physical memory write command
//   pmem_address     physical memory address (16b)
//   pmem_wdata       write data (128b), zero outside WRITE
//   pmem_rdata       read data (128b)
//   pmem_resp        physical memory completion
// -----------------------------------------------------------------------------
module pmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         l2_pmem_read,
    input  logic [15:0]  l2_pmem_raddress,
    output logic [127:0] l2_rdata,
    output logic         l2_resp,
    input  logic         ewb_write,
    input  logic [15:0]  ewb_address,
    input  logic [127:0] ewb_wdata,
    output logic         ewb_done,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
`ifdef EWB_ARB_FWD_EN
    localparam logic [1:0] S_FWD   = 2'd3;
`endif

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [1:0]   state_q, state_d;
    logic [15:0]  addr_q, addr_d;
    logic [127:0] wdata_q, wdata_d;
    logic [2:0]   starve_q, starve_d;
    logic         rd_grant, wr_grant;
    logic         hazard;

    // A pending fill targets the same 16-byte line as the buffered eviction.
    assign hazard = l2_pmem_read & ewb_write &
                    (l2_pmem_raddress[15:4] == ewb_address[15:4]);

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_grant = 1'b0;
        wr_grant = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hazard) begin
`ifdef EWB_ARB_FWD_EN
                    // Answer the fill from the buffered line. The write stays queued.
                    state_d = S_FWD;
                    wdata_d = ewb_wdata;
`else
                    // Drain the dirty line before the fill can read stale memory.
                    wr_grant = 1'b1;
`endif
                end else if (ewb_write && (starve_q == LIMIT)) begin
                    wr_grant = 1'b1;
                end else if (l2_pmem_read) begin
                    rd_grant = 1'b1;
                end else if (ewb_write) begin
                    wr_grant = 1'b1;
                end

                if (wr_grant) begin
                    state_d = S_WRITE;
                    addr_d  = ewb_address;
                    wdata_d = ewb_wdata;
                end
                if (rd_grant) begin
                    state_d = S_READ;
                    addr_d  = l2_pmem_raddress;
                end
            end
            S_READ:  if (pmem_resp) state_d = S_IDLE;
            S_WRITE: if (pmem_resp) state_d = S_IDLE;
            default: state_d = S_IDLE;   // FWD lasts exactly one cycle
        endcase
    end

    // Starvation counter: counts read grants that bypass a waiting write.
    always_comb begin
        starve_d = starve_q;
        if (!ewb_write || wr_grant) begin
            starve_d = 3'd0;
        end else if (rd_grant && (starve_q != LIMIT)) begin
            starve_d = starve_q + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values no matter how the blocks are ordered.
    // NOTE: the address and data latches are ordinary registers, not a memory
    // array. They are reset to zero like the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

    // All outputs decode from the registered state. Reset forces IDLE, so the
    // outputs fall to zero asynchronously with rst_n.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        l2_resp      = 1'b0;
        l2_rdata     = '0;
        ewb_done     = 1'b0;

        case (state_q)
            S_READ: begin
                pmem_read    = 1'b1;
                pmem_address = addr_q;
                if (pmem_resp) begin
                    l2_resp  = 1'b1;
                    l2_rdata = pmem_rdata;
                end
            end
            S_WRITE: begin
                pmem_write   = 1'b1;
                pmem_address = addr_q;
                pmem_wdata   = wdata_q;
                ewb_done     = pmem_resp;
            end
`ifdef EWB_ARB_FWD_EN
            S_FWD: begin
                l2_resp  = 1'b1;
                l2_rdata = wdata_q;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
`timescale 1ns/1ps
module tb_pmem_arbiter;

    localparam int unsigned LIMIT   = 2;
    localparam int          MEM_LAT = 4;   // pmem_resp on the 4th command cycle
    localparam logic        K_R     = 1'b0;
    localparam logic        K_W     = 1'b1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         l2_pmem_read = 1'b0;
    logic [15:0]  l2_pmem_raddress = '0;
    logic [127:0] l2_rdata;
    logic         l2_resp;
    logic         ewb_write = 1'b0;
    logic [15:0]  ewb_address = '0;
    logic [127:0] ewb_wdata = '0;
    logic         ewb_done;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    pmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .l2_pmem_read     (l2_pmem_read),
        .l2_pmem_raddress (l2_pmem_raddress),
        .l2_rdata         (l2_rdata),
        .l2_resp          (l2_resp),
        .ewb_write        (ewb_write),
        .ewb_address      (ewb_address),
        .ewb_wdata        (ewb_wdata),
        .ewb_done         (ewb_done),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [15:0] a);
        return {a, 112'h0123_4567_89AB_CDEF_0011_2233_4455};
    endfunction

    function automatic logic [127:0] wdata_of(input logic [15:0] a);
        return {~a, 16'hBEEF, a, 80'h0};
    endfunction

    // Requester queues, memory model state and event log.
    logic [15:0]  rd_q[$];
    logic [15:0]  wr_q[$];
    int           cyc, mem_cnt, inv_err, rd_cycles;
    logic         prev_rd, prev_wr, stray;
    logic         log_kind[16];
    logic [15:0]  log_addr[16];
    logic [127:0] log_data[16];
    int           log_cyc[16];
    int           log_n;
    int           rsp_cyc[8];
    logic [127:0] rsp_data[8];
    int           rsp_n, done_cyc, done_n;

    task automatic drive();
        l2_pmem_read     = (rd_q.size() != 0);
        l2_pmem_raddress = (rd_q.size() != 0) ? rd_q[0] : 16'h0;
        ewb_write        = (wr_q.size() != 0);
        ewb_address      = (wr_q.size() != 0) ? wr_q[0] : 16'h0;
        ewb_wdata        = (wr_q.size() != 0) ? wdata_of(wr_q[0]) : 128'h0;
    endtask

    task automatic clear_log();
        log_n = 0; rsp_n = 0; done_n = 0; done_cyc = 0;
        rd_cycles = 0; prev_rd = 1'b0; prev_wr = 1'b0; cyc = 1;
    endtask

    // One clock: memory model just after the edge, sample and requesters at negedge.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (pmem_read || pmem_write) begin
            mem_cnt++;
            pmem_resp  = (mem_cnt == MEM_LAT);
            pmem_rdata = (mem_cnt == MEM_LAT) ? line_of(pmem_address) : 128'h0;
        end else begin
            mem_cnt    = 0;
            pmem_resp  = stray;
            pmem_rdata = stray ? 128'hDEAD : 128'h0;
        end
        @(negedge clk);
        if ((!l2_resp && l2_rdata != 0) || (!pmem_write && pmem_wdata != 0) ||
            (pmem_read && pmem_write))
            inv_err++;
        if (pmem_read) rd_cycles++;
        if ((pmem_read && !prev_rd) || (pmem_write && !prev_wr)) begin
            if (log_n < 16) begin
                log_kind[log_n] = pmem_write ? K_W : K_R;
                log_addr[log_n] = pmem_address;
                log_data[log_n] = pmem_wdata;
                log_cyc[log_n]  = cyc;
            end
            log_n++;
        end
        prev_rd = pmem_read;
        prev_wr = pmem_write;
        if (l2_resp) begin
            if (rsp_n < 8) begin
                rsp_cyc[rsp_n]  = cyc;
                rsp_data[rsp_n] = l2_rdata;
            end
            rsp_n++;
            if (rd_q.size() != 0) void'(rd_q.pop_front());
        end
        if (ewb_done) begin
            done_n++;
            done_cyc = cyc;
            if (wr_q.size() != 0) void'(wr_q.pop_front());
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_q.delete();
        wr_q.delete();
        stray = 1'b0;
        drive();
        pmem_resp = 1'b0; pmem_rdata = '0; mem_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
    endtask

    // Run until both queues drain and the port is idle, within a cycle budget.
    task automatic run(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (rd_q.size() == 0 && wr_q.size() == 0 && !pmem_read && !pmem_write) break;
            step();
        end
        check({tag, "_drain"}, 128'(rd_q.size() + wr_q.size()), 128'h0);
    endtask

    initial begin
        inv_err = 0; mem_cnt = 0; stray = 1'b0;
        clear_log();

        // Reset state: every output low while rst_n is asserted.
        #1;
        check("reset_ctrl", {pmem_read, pmem_write, l2_resp, ewb_done, pmem_address}, 128'h0);
        check("reset_data", pmem_wdata | l2_rdata, 128'h0);

        // A stray pmem_resp while IDLE must be ignored.
        do_reset();
        stray = 1'b1;
        step();
        stray = 1'b0;
        check("stray_resp", {l2_resp, ewb_done}, 128'h0);
        step();

        // Single read 0x1230: pmem_read cycles 2-5, l2_resp in cycle 5.
        do_reset();
        rd_q.push_back(16'h1230);
        drive();
        run("rd", 60);
        check("rd_grant", {log_kind[0], log_addr[0]}, {K_R, 16'h1230});
        check("rd_start_cyc", 128'(log_cyc[0]), 128'd2);
        check("rd_cycles", 128'(rd_cycles), 128'd4);
        check("rd_resp_cyc", 128'(rsp_cyc[0]), 128'd5);
        check("rd_resp_data", rsp_data[0], line_of(16'h1230));
        check("rd_resp_cnt", 128'(rsp_n), 128'd1);

        // Simultaneous read 0x1000 and write 0x2000: read first, then write.
        do_reset();
        rd_q.push_back(16'h1000);
        wr_q.push_back(16'h2000);
        drive();
        run("rw", 80);
        check("rw_first", {log_kind[0], log_addr[0], 8'(log_cyc[0])}, {K_R, 16'h1000, 8'd2});
        check("rw_second", {log_kind[1], log_addr[1], 8'(log_cyc[1])}, {K_W, 16'h2000, 8'd7});
        check("rw_wdata", log_data[1], wdata_of(16'h2000));
        check("rw_done", {8'(done_n), 8'(done_cyc)}, {8'd1, 8'd10});

        // Starvation (limit 2): write 0x4000 waits for two reads, then R,R,W,R.
        do_reset();
        rd_q.push_back(16'h1000);
        rd_q.push_back(16'h1010);
        rd_q.push_back(16'h1020);
        wr_q.push_back(16'h4000);
        drive();
        run("st", 120);
        check("st_count", 128'(log_n), 128'd4);
        check("st_g0", {log_kind[0], log_addr[0], 8'(log_cyc[0])}, {K_R, 16'h1000, 8'd2});
        check("st_g1", {log_kind[1], log_addr[1], 8'(log_cyc[1])}, {K_R, 16'h1010, 8'd7});
        check("st_g2", {log_kind[2], log_addr[2], 8'(log_cyc[2])}, {K_W, 16'h4000, 8'd12});
        check("st_g3", {log_kind[3], log_addr[3], 8'(log_cyc[3])}, {K_R, 16'h1020, 8'd17});
        check("st_wdata", log_data[2], wdata_of(16'h4000));

        // Hazard: read 0x3008 against buffered write 0x3000 (same line).
        do_reset();
        rd_q.push_back(16'h3008);
        wr_q.push_back(16'h3000);
        drive();
        run("hz", 80);
`ifdef EWB_ARB_FWD_EN
        check("hz_resp_cyc", 128'(rsp_cyc[0]), 128'd2);
        check("hz_resp_data", rsp_data[0], wdata_of(16'h3000));
        check("hz_no_pmem_read", 128'(rd_cycles), 128'd0);
        check("hz_write", {log_kind[0], log_addr[0], 8'(log_cyc[0])}, {K_W, 16'h3000, 8'd4});
`else
        check("hz_write", {log_kind[0], log_addr[0], 8'(log_cyc[0])}, {K_W, 16'h3000, 8'd2});
        check("hz_done_cyc", 128'(done_cyc), 128'd5);
        check("hz_read", {log_kind[1], log_addr[1], 8'(log_cyc[1])}, {K_R, 16'h3008, 8'd7});
        check("hz_resp", {8'(rsp_cyc[0]), rsp_data[0]}, {8'd10, line_of(16'h3008)});
`endif

        // Reset during WRITE: command drops at once, no ewb_done until reissue.
        do_reset();
        wr_q.push_back(16'h5000);
        drive();
        step();
        step();
        check("rw_mid_write", {pmem_write, pmem_address}, {1'b1, 16'h5000});
        #2 rst_n = 1'b0;
        #1;
        check("rst_drop", {pmem_write, ewb_done, pmem_address}, 128'h0);
        check("rst_wdata", pmem_wdata, 128'h0);
        mem_cnt = 0; pmem_resp = 1'b0; pmem_rdata = '0;
        step();
        step();
        check("rst_no_done", 128'(done_n), 128'd0);
        rst_n = 1'b1;
        run("rst", 60);
        check("rst_reissue", {8'(log_n), log_kind[1], log_addr[1], 8'(log_cyc[1])},
              {8'd2, K_W, 16'h5000, 8'd6});
        check("rst_done", {8'(done_n), 8'(done_cyc)}, {8'd1, 8'd9});

        check("invariants", 128'(inv_err), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends even if a step never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "global timeout");
    end

endmodule
